// File: rtl/csr_pkg.sv
// Shared CSR addresses, exception codes and register layouts for the LA32R CSR file.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  // Software-writable bits of each masked register.
  localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;

  typedef struct packed {
    logic [22:0] rsv;
    logic [1:0]  datm;
    logic [1:0]  datf;
    logic        pg;
    logic        da;
    logic        ie;
    logic [1:0]  plv;
  } crmd_t;

  typedef struct packed {
    logic [28:0] rsv;
    logic        pie;
    logic [1:0]  pplv;
  } prmd_t;

  typedef struct packed {
    logic        rsv31;
    logic [8:0]  esubcode;
    logic [5:0]  ecode;
    logic [2:0]  rsv;
    logic [12:0] is;
  } estat_t;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [31:0] we,
                                               input logic [31:0] wmask);
    logic [31:0] m;
    m = we & wmask;
    return (old_val & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: TVAL down-counter with one-shot / periodic reload and an expiry pulse.
module csr_timer
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tcfg_we_i,
  input  logic [31:0] tcfg_new_i,
  input  logic [31:0] tcfg_i,
  output logic [31:0] tval_o,
  output logic        timer_set_o
);

  logic [31:0] tval_q, tval_d;
  logic        en_q, en_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    tval_d      = tval_q;
    en_d        = en_q;
    timer_set_o = 1'b0;
    if (tcfg_we_i) begin
      tval_d = {tcfg_new_i[31:2], 2'b00};
      en_d   = tcfg_new_i[0];
    end else if (en_q) begin
      if (tval_q != 32'd0) begin
        tval_d = tval_q - 32'd1;
      end else begin
        timer_set_o = 1'b1;
        if (tcfg_i[1]) tval_d = {tcfg_i[31:2], 2'b00};
        else           en_d   = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tval_q <= 32'd0;
      en_q   <= 1'b0;
    end else begin
      tval_q <= tval_d;
      en_q   <= en_d;
    end
  end

  assign tval_o = tval_q;

endmodule

// File: rtl/csr_regfile.sv
// Architectural CSR file: CSR read/write, precise exception entry, ERTN, timer and interrupt request.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] TID_INIT = 32'h0,
  parameter int          N_HWI    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [13:0]      csr_raddr,
  output logic [31:0]      csr_rdata,
  input  logic             wb_valid_a,
  input  logic             wb_valid_b,
  input  logic [13:0]      csr_waddr,
  input  logic [31:0]      csr_we,
  input  logic [31:0]      csr_wdata,
  input  logic             ertn_b,
  input  logic             ecode_we_a,
  input  logic             ecode_we_b,
  input  logic [6:0]       ecode_a,
  input  logic [6:0]       ecode_b,
  input  logic             badv_we_a,
  input  logic             badv_we_b,
  input  logic [31:0]      badv_a,
  input  logic [31:0]      badv_b,
  input  logic [31:0]      pc_a,
  input  logic [31:0]      pc_b,
  input  logic [N_HWI-1:0] hw_int,
  output logic             flush,
  output logic [31:0]      flush_target,
  output logic             has_int,
  output logic [1:0]       crmd_plv
);

  crmd_t       crmd_q, crmd_d;
  prmd_t       prmd_q, prmd_d;
  estat_t      estat_q, estat_d;
  logic [31:0] ecfg_q, ecfg_d, era_q, era_d, badv_q, badv_d;
  logic [31:0] eentry_q, eentry_d, tid_q, tid_d, tcfg_q, tcfg_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic        flush_q, flush_d, has_int_q, has_int_d;
  logic [31:0] flush_target_q, flush_target_d;

  logic        exc_a, exc_b, b_commit, wr_en, tcfg_we, ticlr_clr, timer_set;
  logic [31:0] tcfg_new, tval;
  logic [7:0]  hw_ext;
  logic [6:0]  exc_code;
  logic        exc_badv_we;
  logic [31:0] exc_badv, exc_pc;

  // Pipe A is older, so its exception kills everything pipe B does this cycle.
  assign exc_a     = wb_valid_a & ecode_we_a;
  assign exc_b     = wb_valid_b & ecode_we_b & ~exc_a;
  assign b_commit  = wb_valid_b & ~exc_a & ~exc_b;
  assign wr_en     = b_commit & (|csr_we);
  assign tcfg_we   = wr_en & (csr_waddr == CSR_TCFG);
  assign ticlr_clr = wr_en & (csr_waddr == CSR_TICLR) & csr_we[0] & csr_wdata[0];
  assign tcfg_new  = masked_write(tcfg_q, csr_wdata, csr_we, 32'hFFFF_FFFF);
  assign hw_ext    = 8'(hw_int);

  assign exc_code    = exc_a ? ecode_a   : ecode_b;
  assign exc_badv_we = exc_a ? badv_we_a : badv_we_b;
  assign exc_badv    = exc_a ? badv_a    : badv_b;
  assign exc_pc      = exc_a ? pc_a      : pc_b;

  csr_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .tcfg_we_i   (tcfg_we),
    .tcfg_new_i  (tcfg_new),
    .tcfg_i      (tcfg_q),
    .tval_o      (tval),
    .timer_set_o (timer_set)
  );

  always_comb begin
    crmd_d         = crmd_q;
    prmd_d         = prmd_q;
    estat_d        = estat_q;
    ecfg_d         = ecfg_q;
    era_d          = era_q;
    badv_d         = badv_q;
    eentry_d       = eentry_q;
    tid_d          = tid_q;
    tcfg_d         = tcfg_q;
    save_d         = save_q;
    flush_d        = 1'b0;
    flush_target_d = flush_target_q;

    if (wr_en) begin
      case (csr_waddr)
        CSR_CRMD:   crmd_d   = crmd_t'(masked_write(crmd_q, csr_wdata, csr_we, CRMD_WMASK));
        CSR_PRMD:   prmd_d   = prmd_t'(masked_write(prmd_q, csr_wdata, csr_we, PRMD_WMASK));
        CSR_ECFG:   ecfg_d   = masked_write(ecfg_q, csr_wdata, csr_we, ECFG_WMASK);
        CSR_ESTAT:  estat_d  = estat_t'(masked_write(estat_q, csr_wdata, csr_we, ESTAT_WMASK));
        CSR_ERA:    era_d    = masked_write(era_q, csr_wdata, csr_we, 32'hFFFF_FFFF);
        CSR_BADV:   badv_d   = masked_write(badv_q, csr_wdata, csr_we, 32'hFFFF_FFFF);
        CSR_EENTRY: eentry_d = masked_write(eentry_q, csr_wdata, csr_we, EENTRY_WMASK);
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
          save_d[csr_waddr[1:0]] = masked_write(save_q[csr_waddr[1:0]], csr_wdata, csr_we,
                                                32'hFFFF_FFFF);
        CSR_TID:    tid_d    = masked_write(tid_q, csr_wdata, csr_we, 32'hFFFF_FFFF);
        CSR_TCFG:   tcfg_d   = tcfg_new;
        default:    ;
      endcase
    end

    if (b_commit && ertn_b) begin
      crmd_d.plv     = prmd_q.pplv;
      crmd_d.ie      = prmd_q.pie;
      flush_d        = 1'b1;
      flush_target_d = era_q;
    end

    if (exc_a || exc_b) begin
      prmd_d.pplv      = crmd_q.plv;
      prmd_d.pie       = crmd_q.ie;
      crmd_d.plv       = 2'd0;
      crmd_d.ie        = 1'b0;
      era_d            = exc_pc;
      estat_d.ecode    = exc_code[5:0];
      estat_d.esubcode = {8'b0, exc_code[6]};
      if (exc_badv_we) badv_d = exc_badv;
      flush_d          = 1'b1;
      flush_target_d   = eentry_q;
    end

    // Hardware lines are sampled every cycle; a timer set beats a same-cycle TICLR clear.
    estat_d.is[9:2] = hw_ext;
    estat_d.is[11]  = timer_set | (estat_q.is[11] & ~ticlr_clr);

    has_int_d = (|(estat_q.is & ecfg_q[12:0])) & crmd_q.ie;
  end

  // NOTE: the four SAVE registers are a small flop array, not a RAM, so they are reset with
  // everything else; a real memory macro would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd_q         <= crmd_t'(32'h0000_0008);
      prmd_q         <= '0;
      estat_q        <= '0;
      ecfg_q         <= '0;
      era_q          <= '0;
      badv_q         <= '0;
      eentry_q       <= '0;
      tid_q          <= TID_INIT;
      tcfg_q         <= '0;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
      flush_q        <= 1'b0;
      flush_target_q <= '0;
      has_int_q      <= 1'b0;
    end else begin
      crmd_q         <= crmd_d;
      prmd_q         <= prmd_d;
      estat_q        <= estat_d;
      ecfg_q         <= ecfg_d;
      era_q          <= era_d;
      badv_q         <= badv_d;
      eentry_q       <= eentry_d;
      tid_q          <= tid_d;
      tcfg_q         <= tcfg_d;
      save_q         <= save_d;
      flush_q        <= flush_d;
      flush_target_q <= flush_target_d;
      has_int_q      <= has_int_d;
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      CSR_CRMD:   csr_rdata = crmd_q;
      CSR_PRMD:   csr_rdata = prmd_q;
      CSR_ECFG:   csr_rdata = ecfg_q;
      CSR_ESTAT:  csr_rdata = estat_q;
      CSR_ERA:    csr_rdata = era_q;
      CSR_BADV:   csr_rdata = badv_q;
      CSR_EENTRY: csr_rdata = eentry_q;
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                  csr_rdata = save_q[csr_raddr[1:0]];
      CSR_TID:    csr_rdata = tid_q;
      CSR_TCFG:   csr_rdata = tcfg_q;
      CSR_TVAL:   csr_rdata = tval;
      default:    csr_rdata = 32'd0;
    endcase
  end

  assign flush        = flush_q;
  assign flush_target = flush_target_q;
  assign has_int      = has_int_q;
  assign crmd_plv     = crmd_q.plv;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset, masked writes, exceptions, ERTN, timer and interrupts.
module tb_csr_regfile;
  import csr_pkg::*;

  localparam logic [31:0] TID_INIT = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] csr_raddr = '0;
  logic [31:0] csr_rdata;
  logic        wb_valid_a = 0, wb_valid_b = 0;
  logic [13:0] csr_waddr = '0;
  logic [31:0] csr_we = '0, csr_wdata = '0;
  logic        ertn_b = 0, ecode_we_a = 0, ecode_we_b = 0;
  logic [6:0]  ecode_a = '0, ecode_b = '0;
  logic        badv_we_a = 0, badv_we_b = 0;
  logic [31:0] badv_a = '0, badv_b = '0, pc_a = '0, pc_b = '0;
  logic [7:0]  hw_int = '0;
  logic        flush, has_int;
  logic [31:0] flush_target;
  logic [1:0]  crmd_plv;

  int errors = 0;
  int checks = 0;

  csr_regfile #(.TID_INIT(TID_INIT), .N_HWI(8)) dut (
    .clk(clk), .rst(rst), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .wb_valid_a(wb_valid_a), .wb_valid_b(wb_valid_b), .csr_waddr(csr_waddr),
    .csr_we(csr_we), .csr_wdata(csr_wdata), .ertn_b(ertn_b),
    .ecode_we_a(ecode_we_a), .ecode_we_b(ecode_we_b), .ecode_a(ecode_a), .ecode_b(ecode_b),
    .badv_we_a(badv_we_a), .badv_we_b(badv_we_b), .badv_a(badv_a), .badv_b(badv_b),
    .pc_a(pc_a), .pc_b(pc_b), .hw_int(hw_int), .flush(flush), .flush_target(flush_target),
    .has_int(has_int), .crmd_plv(crmd_plv)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    csr_raddr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
    wb_valid_b = 1'b1; csr_waddr = a; csr_we = m; csr_wdata = d;
    tick();
    wb_valid_b = 1'b0; csr_we = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rd(CSR_CRMD, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL reset_crmd got=%h exp=%h", d, 32'h8); end
    rd(CSR_TID, d);
    checks++; if (d !== TID_INIT) begin errors++; $display("FAIL reset_tid got=%h exp=%h", d, TID_INIT); end
    rd(CSR_ESTAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_estat got=%h exp=0", d); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL reset_has_int got=%b exp=0", has_int); end
  endtask

  task automatic test_masked_write();
    logic [31:0] d;
    csr_write(CSR_SAVE0, 32'hFFFF_FFFF, 32'hFFFF_0000);
    csr_write(CSR_SAVE0, 32'h0000_FF00, 32'h1234_5678);
    rd(CSR_SAVE0, d);
    checks++; if (d !== 32'hFFFF_5600) begin errors++; $display("FAIL masked_save0 got=%h exp=%h", d, 32'hFFFF_5600); end
    rd(CSR_TICLR, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ticlr_reads0 got=%h exp=0", d); end
    rd(14'h003, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unimpl_read got=%h exp=0", d); end
  endtask

  task automatic test_exc_priority();
    logic [31:0] d;
    csr_write(CSR_EENTRY, 32'hFFFF_FFFF, 32'h1C00_803F);  // low 6 bits are read-only
    csr_write(CSR_SAVE1, 32'hFFFF_FFFF, 32'hAAAA_5555);
    csr_write(CSR_CRMD, 32'hFFFF_FFFF, 32'h0000_000F);
    checks++; if (crmd_plv !== 2'd3) begin errors++; $display("FAIL plv_set got=%0d exp=3", crmd_plv); end
    wb_valid_a = 1; ecode_we_a = 1; ecode_a = {1'b0, ECODE_ADEF};
    badv_we_a = 1; badv_a = 32'h1C00_0004; pc_a = 32'h1C00_0004;
    wb_valid_b = 1; csr_waddr = CSR_SAVE1; csr_we = 32'hFFFF_FFFF; csr_wdata = 32'hDEAD_BEEF;
    tick();
    wb_valid_a = 0; ecode_we_a = 0; badv_we_a = 0; wb_valid_b = 0; csr_we = '0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_flush got=%b exp=1", flush); end
    checks++; if (flush_target !== 32'h1C00_8000) begin errors++; $display("FAIL exc_target got=%h exp=%h", flush_target, 32'h1C00_8000); end
    checks++; if (crmd_plv !== 2'd0) begin errors++; $display("FAIL exc_plv got=%0d exp=0", crmd_plv); end
    rd(CSR_ERA, d);
    checks++; if (d !== 32'h1C00_0004) begin errors++; $display("FAIL exc_era got=%h exp=%h", d, 32'h1C00_0004); end
    rd(CSR_BADV, d);
    checks++; if (d !== 32'h1C00_0004) begin errors++; $display("FAIL exc_badv got=%h exp=%h", d, 32'h1C00_0004); end
    rd(CSR_PRMD, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL exc_prmd got=%h exp=7", d); end
    rd(CSR_CRMD, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL exc_crmd got=%h exp=8", d); end
    rd(CSR_SAVE1, d);
    checks++; if (d !== 32'hAAAA_5555) begin errors++; $display("FAIL exc_save1 got=%h exp=%h", d, 32'hAAAA_5555); end
    rd(CSR_ESTAT, d);
    checks++; if (d !== 32'h0008_0000) begin errors++; $display("FAIL exc_estat got=%h exp=%h", d, 32'h0008_0000); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_pulse got=%b exp=0", flush); end
  endtask

  task automatic do_ertn(input string tag);
    logic [31:0] d;
    wb_valid_b = 1; ertn_b = 1;
    tick();
    wb_valid_b = 0; ertn_b = 0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL %s_flush got=%b exp=1", tag, flush); end
    rd(CSR_ERA, d);
    checks++; if (flush_target !== d || d === 32'h0) begin errors++; $display("FAIL %s_target got=%h era=%h", tag, flush_target, d); end
    rd(CSR_CRMD, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL %s_crmd got=%h exp=f", tag, d); end
  endtask

  task automatic test_ertn();
    do_ertn("ertn");
    checks++; if (flush_target !== 32'h1C00_0004) begin errors++; $display("FAIL ertn_era_target got=%h exp=%h", flush_target, 32'h1C00_0004); end
  endtask

  task automatic test_exc_b();
    logic [31:0] d;
    wb_valid_a = 1;
    wb_valid_b = 1; ecode_we_b = 1; ecode_b = {1'b1, ECODE_SYS}; badv_we_b = 0;
    badv_b = 32'h5555_5555; pc_b = 32'h1C00_0100;
    csr_waddr = CSR_SAVE2; csr_we = 32'hFFFF_FFFF; csr_wdata = 32'h0000_1234;
    tick();
    wb_valid_a = 0; wb_valid_b = 0; ecode_we_b = 0; csr_we = '0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL excb_flush got=%b exp=1", flush); end
    rd(CSR_ERA, d);
    checks++; if (d !== 32'h1C00_0100) begin errors++; $display("FAIL excb_era got=%h exp=%h", d, 32'h1C00_0100); end
    rd(CSR_BADV, d);
    checks++; if (d !== 32'h1C00_0004) begin errors++; $display("FAIL excb_badv got=%h exp=%h", d, 32'h1C00_0004); end
    rd(CSR_ESTAT, d);
    checks++; if (d !== 32'h004B_0000) begin errors++; $display("FAIL excb_estat got=%h exp=%h", d, 32'h004B_0000); end
    rd(CSR_SAVE2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL excb_save2 got=%h exp=0", d); end
    rd(CSR_PRMD, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL excb_prmd got=%h exp=7", d); end
    tick();
    do_ertn("ertn2");
    checks++; if (flush_target !== 32'h1C00_0100) begin errors++; $display("FAIL ertn2_era_target got=%h exp=%h", flush_target, 32'h1C00_0100); end
  endtask

  task automatic test_oneshot_timer();
    logic [31:0] d;
    csr_write(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_0800);
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
    rd(CSR_TVAL, d);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL os_tval_load got=%0d exp=16", d); end
    repeat (16) tick();
    rd(CSR_TVAL, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_tval_zero got=%0d exp=0", d); end
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b0) begin errors++; $display("FAIL os_is11_early got=%b exp=0", d[11]); end
    tick();
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b1) begin errors++; $display("FAIL os_is11_set got=%b exp=1", d[11]); end
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL os_has_int_lat got=%b exp=0", has_int); end
    tick();
    checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL os_has_int got=%b exp=1", has_int); end
    repeat (3) tick();
    rd(CSR_TVAL, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_tval_stays0 got=%0d exp=0", d); end
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b1) begin errors++; $display("FAIL os_is11_hold got=%b exp=1", d[11]); end
    csr_write(CSR_TICLR, 32'hFFFF_FFFF, 32'h1);
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b0) begin errors++; $display("FAIL os_ticlr got=%b exp=0", d[11]); end
    checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL os_has_int_hold got=%b exp=1", has_int); end
    tick();
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL os_has_int_fall got=%b exp=0", has_int); end
  endtask

  task automatic test_periodic_timer();
    logic [31:0] d;
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0007);
    repeat (4) tick();
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b0) begin errors++; $display("FAIL per_is11_c4 got=%b exp=0", d[11]); end
    tick();
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b1) begin errors++; $display("FAIL per_is11_c5 got=%b exp=1", d[11]); end
    csr_write(CSR_TICLR, 32'h1, 32'h1);
    repeat (3) tick();
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b0) begin errors++; $display("FAIL per_is11_c9 got=%b exp=0", d[11]); end
    tick();
    rd(CSR_ESTAT, d);
    checks++; if (d[11] !== 1'b1) begin errors++; $display("FAIL per_is11_c10 got=%b exp=1", d[11]); end
    rd(CSR_TVAL, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL per_reload got=%0d exp=4", d); end
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0);
    csr_write(CSR_TICLR, 32'h1, 32'h1);
  endtask

  task automatic test_hw_int();
    logic [31:0] d;
    hw_int = 8'h01;
    rd(CSR_ESTAT, d);
    checks++; if (d[2] !== 1'b0) begin errors++; $display("FAIL hw_before got=%b exp=0", d[2]); end
    tick();
    rd(CSR_ESTAT, d);
    checks++; if (d[12:0] !== 13'h0004) begin errors++; $display("FAIL hw_is got=%h exp=%h", d[12:0], 13'h0004); end
    hw_int = 8'h00;
    tick();
    rd(CSR_ESTAT, d);
    checks++; if (d[2] !== 1'b0) begin errors++; $display("FAIL hw_drop got=%b exp=0", d[2]); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
    wb_valid_a = 1; ecode_we_a = 1; ecode_a = {1'b0, ECODE_BRK};
    #2 rst = 1'b1;
    #1;
    wb_valid_a = 0; ecode_we_a = 0;
    rd(CSR_CRMD, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL mrst_crmd got=%h exp=8", d); end
    rd(CSR_TVAL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mrst_tval got=%h exp=0", d); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mrst_flush got=%b exp=0", flush); end
    rst = 1'b0;
    tick();
    rd(CSR_TVAL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mrst_timer_off got=%h exp=0", d); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_masked_write();
    test_exc_priority();
    test_ertn();
    test_exc_b();
    test_oneshot_timer();
    test_periodic_timer();
    test_hw_int();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
